// File: rtl/sum_display_driver.sv
// Two-digit multiplexed 7-segment driver for a 5-bit adder sum.
// Shows 0..31 in decimal, a dash pair on carry-out, blank until first load.
module sum_display_driver #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] sum_in,
  input  logic       co_in,
  input  logic       load,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       disp_valid
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [1:0] AN_OFF    = 2'b11;
  localparam logic [1:0] AN_UNITS  = 2'b10;
  localparam logic [1:0] AN_TENS   = 2'b01;

  logic [4:0]    r_value;
  logic          r_err;
  logic          r_valid;
  logic [CW-1:0] r_cnt;
  logic          r_sel;
  logic [6:0]    r_seg;
  logic [1:0]    r_an;

  logic [3:0]    w_tens;
  logic [3:0]    w_units;
  logic [6:0]    w_seg_d;
  logic [1:0]    w_an_d;

  function automatic logic [6:0] f_enc(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
    end else if (load) begin
      r_value <= sum_in;
      r_err   <= co_in;
      r_valid <= 1'b1;
    end
  end

  // r_sel: 0 = units slot, 1 = tens slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sel <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
      r_sel <= ~r_sel;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_comb begin
    w_tens  = 4'(r_value / 5'd10);
    w_units = 4'(r_value % 5'd10);
    w_seg_d = SEG_BLANK;
    w_an_d  = AN_OFF;
    unique case (1'b1)
      !r_valid: begin
        w_seg_d = SEG_BLANK;
        w_an_d  = AN_OFF;
      end
      r_valid && !r_sel: begin
        w_an_d  = AN_UNITS;
        w_seg_d = r_err ? SEG_DASH
                        : f_enc(w_units);
      end
      r_valid && r_sel: begin
        w_an_d = AN_TENS;
        if (r_err)
          w_seg_d = SEG_DASH;
        else if (w_tens == 4'd0)
          w_seg_d = SEG_BLANK;
        else
          w_seg_d = f_enc(w_tens);
      end
      default: begin
        w_seg_d = SEG_BLANK;
        w_an_d  = AN_OFF;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= SEG_BLANK;
      r_an  <= AN_OFF;
    end else begin
      r_seg <= w_seg_d;
      r_an  <= w_an_d;
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign disp_valid = r_valid;

endmodule

// File: tb/tb_sum_display_driver.sv
// Bench for sum_display_driver: directed scenarios plus random loads,
// checked against a decimal-display reference model.
module tb_sum_display_driver;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] sum_in = '0;
  logic       co_in = 1'b0;
  logic       load = 1'b0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       disp_valid;

  int checks = 0;
  int errors = 0;

  int m_value;
  int m_err;
  int m_valid;
  int m_n;

  logic [6:0] exp_seg;
  logic [1:0] exp_an;

  sum_display_driver #(.SCAN_DIV(SD)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sum_in(sum_in),
    .co_in(co_in),
    .load(load),
    .seg(seg),
    .an(an),
    .disp_valid(disp_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] enc(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return tbl[d];
  endfunction

  // slot 0 shows units, slot 1 shows tens
  function automatic logic [8:0] disp(
    input int slot, input int v, input int e, input int val
  );
    if (val == 0) return {2'b11, 7'h7F};
    if (slot == 0)
      return {2'b10, (e != 0) ? 7'h3F : enc(v % 10)};
    if (e != 0) return {2'b01, 7'h3F};
    if (v / 10 == 0) return {2'b01, 7'h7F};
    return {2'b01, enc(v / 10)};
  endfunction

  task automatic check(
    input string tag, input logic [7:0] obs, input logic [7:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_value = 0;
    m_err   = 0;
    m_valid = 0;
    m_n     = 0;
  endtask

  task automatic step(input bit ld, input int s, input bit c);
    int pslot;
    pslot  = (m_n / SD) % 2;
    load   = ld;
    sum_in = 5'(s);
    co_in  = c;
    @(posedge clk);
    {exp_an, exp_seg} = disp(pslot, m_value, m_err, m_valid);
    if (ld) begin
      m_value = s;
      m_err   = c;
      m_valid = 1;
    end
    m_n++;
    @(negedge clk);
    check("seg", {1'b0, seg}, {1'b0, exp_seg});
    check("an", {6'b0, an}, {6'b0, exp_an});
    check("disp_valid", {7'b0, disp_valid}, 8'(m_valid));
    if (m_valid != 0 && m_n > 1)
      check("an_onehot", {7'b0, an == 2'b00}, 8'd0);
    load = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_seg", {1'b0, seg}, 8'h7F);
    check("rst_an", {6'b0, an}, 8'h03);
    check("rst_valid", {7'b0, disp_valid}, 8'h00);
    rst_n = 1'b1;
    model_reset();

    idle(10);

    step(1'b1, 21, 1'b0);
    idle(12);

    step(1'b1, 7, 1'b0);
    idle(10);

    step(1'b1, 30, 1'b1);
    idle(9);
    step(1'b1, 9, 1'b0);
    idle(9);

    while (((m_n + 1) % SD) != 0) step(1'b0, 0, 1'b0);
    step(1'b1, 31, 1'b0);
    idle(9);

    for (int i = 0; i < 6; i++) step(1'b1, 3 * i + 2, i[0]);
    idle(5);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0)
        step(1'b1, int'($urandom_range(0, 31)),
             $urandom_range(0, 4) == 0);
      else
        step(1'b0, int'($urandom_range(0, 31)), 1'b0);
    end

    step(1'b1, 25, 1'b0);
    idle(6);
    #2 rst_n = 1'b0;
    #1;
    check("async_seg", {1'b0, seg}, 8'h7F);
    check("async_an", {6'b0, an}, 8'h03);
    check("async_valid", {7'b0, disp_valid}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle(6);

    load   = 1'b1;
    sum_in = 5'd19;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_load_valid", {7'b0, disp_valid}, 8'h00);
    @(negedge clk);
    load  = 1'b0;
    rst_n = 1'b1;
    model_reset();
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
